// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard for the ID stage.
// Tracks outstanding writes per GPR with a saturating-free counter, flags
// RAW hazards per read port and withholds issue while any operand is pending.
// Optional feature macro: SB_WB_BYPASS_EN (same-cycle writeback forwarding
// removes the hazard/saturation on the last retiring write).
module reg_scoreboard #(
   parameter int ADDR_WIDTH  = 5,
   parameter int READ_PORTS  = 2,
   parameter int MAX_PENDING = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             issue_valid,
   output logic                             issue_ready,
   input  logic [READ_PORTS-1:0]            rd_en,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic                             wb_en,
   input  logic [ADDR_WIDTH-1:0]            wb_addr,
   input  logic                             flush,
   output logic [READ_PORTS-1:0]            hazard,
   output logic [2**ADDR_WIDTH-1:0]         busy_map,
   output logic                             wb_err
);

   localparam int NREG  = 2**ADDR_WIDTH;
   localparam int CNT_W = $clog2(MAX_PENDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] count [NREG];
   logic             sat;
   logic             fire;
   logic             wb_live;
   logic             wb_stray;
   logic [NREG-1:0]  inc_vec;
   logic [NREG-1:0]  dec_vec;

   // Writeback classification: retires a pending write, or hits an idle register
   always_comb begin
      wb_live  = wb_en && (wb_addr != '0) && (count[wb_addr] != '0);
      wb_stray = wb_en && (wb_addr != '0) && (count[wb_addr] == '0);
   end

   // Per-port RAW hazard check against the registered counts
   always_comb begin
      logic [ADDR_WIDTH-1:0] ra;
      ra     = '0;
      hazard = '0;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
         ra        = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         hazard[i] = rd_en[i] && (ra != '0) && (count[ra] != '0);
`ifdef SB_WB_BYPASS_EN
         // last outstanding write retires now; WB forwards its data
         if (wb_en && (wb_addr == ra) && (count[ra] == CNT_ONE))
            hazard[i] = 1'b0;
`endif
      end
   end

   // Saturation guard and issue handshake
   always_comb begin
      sat = wr_en && (wr_addr != '0) && (count[wr_addr] == CNT_MAX);
`ifdef SB_WB_BYPASS_EN
      // a same-register writeback frees the slot this write would take
      if (wb_en && (wb_addr == wr_addr))
         sat = 1'b0;
`endif
      issue_ready = !rst && !flush && !(|hazard) && !sat;
      fire        = issue_valid && issue_ready;
   end

   // One-hot increment/decrement requests per register
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (fire && wr_en && (wr_addr != '0))
         inc_vec[wr_addr] = 1'b1;
      if (wb_live)
         dec_vec[wb_addr] = 1'b1;
   end

   // Busy map decoded from the counters
   always_comb begin
      busy_map = '0;
      for (int unsigned r = 0; r < NREG; r++)
         busy_map[r] = (count[r] != '0);
   end

   // Counter update; flush wins over any simultaneous inc/dec
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++)
            count[r] <= '0;
      end else if (flush) begin
         for (int unsigned r = 0; r < NREG; r++)
            count[r] <= '0;
      end else begin
         for (int unsigned r = 1; r < NREG; r++) begin
            if (inc_vec[r] && !dec_vec[r])
               count[r] <= count[r] + CNT_ONE;
            else if (dec_vec[r] && !inc_vec[r])
               count[r] <= count[r] - CNT_ONE;
         end
      end
   end

   // One-cycle error pulse for a writeback with nothing outstanding
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wb_err <= 1'b0;
      else
         wb_err <= wb_stray && !flush;
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard (default parameters).
module tb_reg_scoreboard;

`ifdef SB_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic        issue_ready;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic        flush;
   logic [1:0]  hazard;
   logic [31:0] busy_map;
   logic        wb_err;

   int n_cmp;
   int n_bad;

   reg_scoreboard #(
      .ADDR_WIDTH (5),
      .READ_PORTS (2),
      .MAX_PENDING(3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .issue_valid(issue_valid),
      .issue_ready(issue_ready),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .flush      (flush),
      .hazard     (hazard),
      .busy_map   (busy_map),
      .wb_err     (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        v;
      logic [1:0]  re;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        we;
      logic [4:0]  wa;
      logic        wbe;
      logic [4:0]  wba;
      logic        fl;
      logic        e_rdy;
      logic [1:0]  e_haz;
      logic [31:0] e_busy;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] bm(input int r);
      logic [31:0] one;
      one = 32'h1;
      return one << r;
   endfunction

   task automatic add(input string name, input logic v, input logic [1:0] re,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic we, input logic [4:0] wa,
                      input logic wbe, input logic [4:0] wba, input logic fl,
                      input logic e_rdy, input logic [1:0] e_haz,
                      input logic [31:0] e_busy, input logic e_err);
      vec_t t;
      t.name = name; t.v = v; t.re = re; t.ra0 = ra0; t.ra1 = ra1;
      t.we = we; t.wa = wa; t.wbe = wbe; t.wba = wba; t.fl = fl;
      t.e_rdy = e_rdy; t.e_haz = e_haz; t.e_busy = e_busy; t.e_err = e_err;
      tbl.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      issue_valid = t.v;
      rd_en       = t.re;
      rd_addr     = {t.ra1, t.ra0};
      wr_en       = t.we;
      wr_addr     = t.wa;
      wb_en       = t.wbe;
      wb_addr     = t.wba;
      flush       = t.fl;
   endtask

   initial begin
      vec_t idle;
      n_cmp = 0;
      n_bad = 0;

      //  name          v  re     ra0 ra1 we wa  wbe wba fl  rdy   haz          busy               err
      add("wr8",        1, 2'b00, 0,  0,  1, 8,  0,  0,  0,  1,    2'b00,       bm(8),             0);
      add("raw8",       1, 2'b01, 8,  0,  0, 0,  0,  0,  0,  0,    2'b01,       bm(8),             0);
      add("raw8_wb",    1, 2'b01, 8,  0,  0, 0,  1,  8,  0,  BYP,  BYP ? 2'b00 : 2'b01, 32'h0,    0);
      add("rd8_clear",  1, 2'b01, 8,  0,  0, 0,  0,  0,  0,  1,    2'b00,       32'h0,             0);
      add("wr5_a",      1, 2'b00, 0,  0,  1, 5,  0,  0,  0,  1,    2'b00,       bm(5),             0);
      add("wr5_b",      1, 2'b00, 0,  0,  1, 5,  0,  0,  0,  1,    2'b00,       bm(5),             0);
      add("wr5_c",      1, 2'b00, 0,  0,  1, 5,  0,  0,  0,  1,    2'b00,       bm(5),             0);
      add("wr5_sat",    1, 2'b00, 0,  0,  1, 5,  0,  0,  0,  0,    2'b00,       bm(5),             0);
      add("wr5_sat_wb", 1, 2'b00, 0,  0,  1, 5,  1,  5,  0,  BYP,  2'b00,       bm(5),             0);
      add("wr5_after",  1, 2'b00, 0,  0,  1, 5,  0,  0,  0,  !BYP, 2'b00,       bm(5),             0);
      add("reg0",       1, 2'b11, 0,  0,  1, 0,  0,  0,  0,  1,    2'b00,       bm(5),             0);
      add("wb_stray12", 0, 2'b00, 0,  0,  0, 0,  1,  12, 0,  1,    2'b00,       bm(5),             1);
      add("err_drop",   0, 2'b00, 0,  0,  0, 0,  0,  0,  0,  1,    2'b00,       bm(5),             0);
      add("wr6",        1, 2'b00, 0,  0,  1, 6,  0,  0,  0,  1,    2'b00,       bm(5) | bm(6),     0);
      add("flush_wr9",  1, 2'b00, 0,  0,  1, 9,  1,  12, 1,  0,    2'b00,       32'h0,             0);
      add("wb_zero",    0, 2'b00, 0,  0,  0, 0,  1,  0,  0,  1,    2'b00,       32'h0,             0);
      add("wr3",        1, 2'b00, 0,  0,  1, 3,  0,  0,  0,  1,    2'b00,       bm(3),             0);
      add("raw3_port1", 1, 2'b10, 3,  3,  0, 0,  0,  0,  0,  0,    2'b10,       bm(3),             0);
      add("waw3",       1, 2'b00, 0,  0,  1, 3,  0,  0,  0,  1,    2'b00,       bm(3),             0);
      add("stall_wr7",  1, 2'b01, 3,  0,  1, 7,  0,  0,  0,  0,    2'b01,       bm(3),             0);
      add("incdec3",    1, 2'b00, 0,  0,  1, 3,  1,  3,  0,  1,    2'b00,       bm(3),             0);
      add("wb3_a",      0, 2'b00, 0,  0,  0, 0,  1,  3,  0,  1,    2'b00,       bm(3),             0);
      add("wb3_b",      0, 2'b00, 0,  0,  0, 0,  1,  3,  0,  1,    2'b00,       32'h0,             0);
      add("wr3_again",  1, 2'b00, 0,  0,  1, 3,  0,  0,  0,  1,    2'b00,       bm(3),             0);

      // reset state, with reads presented to confirm no hazard and no ready
      idle = '{name: "idle", v: 0, re: 0, ra0: 0, ra1: 0, we: 0, wa: 0, wbe: 0,
               wba: 0, fl: 0, e_rdy: 0, e_haz: 0, e_busy: 0, e_err: 0};
      rst = 1'b1;
      drive(idle);
      issue_valid = 1'b1;
      rd_en       = 2'b11;
      rd_addr     = {5'd9, 5'd8};
      #1;
      check("rst_ready",  {31'b0, issue_ready}, 32'h0);
      check("rst_hazard", {30'b0, hazard},      32'h0);
      check("rst_busy",   busy_map,             32'h0);
      check("rst_wb_err", {31'b0, wb_err},      32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(idle);

      foreach (tbl[k]) begin
         @(negedge clk);
         drive(tbl[k]);
         #1;
         check({tbl[k].name, ".ready"},  {31'b0, issue_ready}, {31'b0, tbl[k].e_rdy});
         check({tbl[k].name, ".hazard"}, {30'b0, hazard},      {30'b0, tbl[k].e_haz});
         @(posedge clk);
         #1;
         check({tbl[k].name, ".busy"},   busy_map,             tbl[k].e_busy);
         check({tbl[k].name, ".wb_err"}, {31'b0, wb_err},      {31'b0, tbl[k].e_err});
      end

      // asynchronous reset asserted mid-cycle while a reader of $3 is stalled
      @(negedge clk);
      drive(idle);
      issue_valid = 1'b1;
      rd_en       = 2'b01;
      rd_addr     = {5'd0, 5'd3};
      #1;
      check("stall3.hazard", {30'b0, hazard},      32'h1);
      check("stall3.ready",  {31'b0, issue_ready}, 32'h0);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst.busy",   busy_map,             32'h0);
      check("async_rst.ready",  {31'b0, issue_ready}, 32'h0);
      check("async_rst.hazard", {30'b0, hazard},      32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(idle);
      #1;
      check("post_rst.busy", busy_map, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
